// File: rtl/t03_alu_issue.sv
// t03_alu_issue: decode/issue front end for a combinational RV32I ALU.
// Optional macro T03_ALU_ISSUE_OVERLAP_EN lets a new instruction enter while the last packet retires.
`timescale 1ns/1ps
module t03_alu_issue #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] alu_imm,
    output logic [3:0]      alu_fop,
    output logic            alu_mux_en,
    output logic            alu_u,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_z,
    input  logic            alu_n,
    input  logic            alu_v,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_we,
    output logic            br_taken,
    output logic            illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_ILL  = 3'd0,
        K_ALU  = 3'd1,
        K_SLT  = 3'd2,
        K_SLTU = 3'd3,
        K_LUI  = 3'd4,
        K_BR   = 3'd5
    } kind_t;

    localparam logic [3:0] FOP_ADD = 4'd0;
    localparam logic [3:0] FOP_SUB = 4'd1;
    localparam logic [3:0] FOP_SLL = 4'd2;
    localparam logic [3:0] FOP_SRL = 4'd3;
    localparam logic [3:0] FOP_SRA = 4'd4;
    localparam logic [3:0] FOP_AND = 4'd5;
    localparam logic [3:0] FOP_OR  = 4'd6;
    localparam logic [3:0] FOP_XOR = 4'd7;
    localparam logic [3:0] FOP_IMM = 4'd8;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    state_t          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            v_q, v_d;
    logic            a31_q, a31_d;
    logic            b31_q, b31_d;

    logic            accept;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [RD_W-1:0] rd;

    kind_t           kind;
    logic [3:0]      dec_fop;
    logic            dec_mux_en;
    logic            dec_u;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [XLEN-1:0] b_eff;
    logic            lt_s;
    logic            lt_u;
    logic            br_cond;

    assign opcode = instr_q[6:0];
    assign f3     = instr_q[14:12];
    assign f7     = instr_q[31:25];
    assign rd     = instr_q[11:7];

`ifdef T03_ALU_ISSUE_OVERLAP_EN
    assign inst_ready = (state_q == IDLE) | ((state_q == DONE) & wb_ready);
`else
    assign inst_ready = (state_q == IDLE);
`endif

    assign accept = inst_valid & inst_ready;

    // Decode the latched instruction into ALU controls and a result kind
    always_comb begin
        kind       = K_ILL;
        dec_fop    = FOP_ADD;
        dec_mux_en = 1'b0;
        dec_u      = 1'b0;
        dec_imm    = '0;
        dec_a      = '0;
        dec_b      = '0;
        unique case (opcode)
            OP_R: begin
                dec_a = rs1_q;
                dec_b = rs2_q;
                kind  = K_ALU;
                unique case (f3)
                    3'b000: dec_fop = f7[5] ? FOP_SUB : FOP_ADD;
                    3'b001: begin
                        dec_fop = FOP_SLL;
                        dec_b   = {{(XLEN-5){1'b0}}, rs2_q[4:0]};
                    end
                    3'b010: begin
                        dec_fop = FOP_SUB;
                        kind    = K_SLT;
                    end
                    3'b011: begin
                        dec_fop = FOP_SUB;
                        dec_u   = 1'b1;
                        kind    = K_SLTU;
                    end
                    3'b100: dec_fop = FOP_XOR;
                    3'b101: begin
                        dec_fop = f7[5] ? FOP_SRA : FOP_SRL;
                        dec_b   = {{(XLEN-5){1'b0}}, rs2_q[4:0]};
                    end
                    3'b110: dec_fop = FOP_OR;
                    default: dec_fop = FOP_AND;
                endcase
                // Only SUB and SRA may use the alternate funct7
                if (!((f7 == 7'h00) ||
                      ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)))))
                    kind = K_ILL;
            end
            OP_I: begin
                dec_a      = rs1_q;
                dec_mux_en = 1'b1;
                dec_imm    = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
                kind       = K_ALU;
                unique case (f3)
                    3'b000: dec_fop = FOP_ADD;
                    3'b001: begin
                        dec_fop = FOP_SLL;
                        dec_imm = {{(XLEN-5){1'b0}}, instr_q[24:20]};
                        if (f7 != 7'h00)
                            kind = K_ILL;
                    end
                    3'b010: begin
                        dec_fop = FOP_SUB;
                        kind    = K_SLT;
                    end
                    3'b011: begin
                        dec_fop = FOP_SUB;
                        dec_u   = 1'b1;
                        kind    = K_SLTU;
                    end
                    3'b100: dec_fop = FOP_XOR;
                    3'b101: begin
                        dec_fop = f7[5] ? FOP_SRA : FOP_SRL;
                        dec_imm = {{(XLEN-5){1'b0}}, instr_q[24:20]};
                        if ((f7 != 7'h00) && (f7 != 7'h20))
                            kind = K_ILL;
                    end
                    3'b110: dec_fop = FOP_OR;
                    default: dec_fop = FOP_AND;
                endcase
            end
            OP_LUI: begin
                dec_fop    = FOP_IMM;
                dec_mux_en = 1'b1;
                dec_imm    = {instr_q[31:12], 12'b0};
                kind       = K_LUI;
            end
            OP_BR: begin
                dec_a   = rs1_q;
                dec_b   = rs2_q;
                dec_fop = FOP_SUB;
                dec_u   = (f3 == 3'b110) || (f3 == 3'b111);
                kind    = ((f3 == 3'b010) || (f3 == 3'b011)) ? K_ILL : K_BR;
            end
            default: kind = K_ILL;
        endcase
        // Undecodable words leave the ALU idle
        if (kind == K_ILL) begin
            dec_fop    = FOP_ADD;
            dec_mux_en = 1'b0;
            dec_u      = 1'b0;
            dec_imm    = '0;
            dec_a      = '0;
            dec_b      = '0;
        end
    end

    assign b_eff = dec_mux_en ? dec_imm : dec_b;

    // ALU controls are live only while executing
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_imm    = '0;
        alu_fop    = '0;
        alu_mux_en = 1'b0;
        alu_u      = 1'b0;
        if (state_q == EXEC) begin
            alu_a      = dec_a;
            alu_b      = dec_b;
            alu_imm    = dec_imm;
            alu_fop    = dec_fop;
            alu_mux_en = dec_mux_en;
            alu_u      = dec_u;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = DONE;
            DONE: if (wb_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch on accept, result capture at the end of EXEC
    always_comb begin
        instr_d = instr_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        res_d   = res_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        a31_d   = a31_q;
        b31_d   = b31_q;
        if (accept) begin
            instr_d = instr;
            rs1_d   = rs1_data;
            rs2_d   = rs2_data;
        end
        if (state_q == EXEC) begin
            res_d = alu_result;
            z_d   = alu_z;
            n_d   = alu_n;
            v_d   = alu_v;
            a31_d = dec_a[XLEN-1];
            b31_d = b_eff[XLEN-1];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            a31_q   <= 1'b0;
            b31_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            a31_q   <= a31_d;
            b31_q   <= b31_d;
        end
    end

    assign lt_s = n_q ^ v_q;
    assign lt_u = (~a31_q & b31_q) | (~(a31_q ^ b31_q) & res_q[XLEN-1]);

    // Branch condition from the registered flags
    always_comb begin
        br_cond = 1'b0;
        unique case (f3)
            3'b000: br_cond = z_q;
            3'b001: br_cond = ~z_q;
            3'b100: br_cond = lt_s;
            3'b101: br_cond = ~lt_s;
            3'b110: br_cond = lt_u;
            3'b111: br_cond = ~lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    // Write-back packet, held while DONE
    always_comb begin
        wb_valid = 1'b0;
        wb_data  = '0;
        wb_rd    = '0;
        wb_we    = 1'b0;
        br_taken = 1'b0;
        illegal  = 1'b0;
        if (state_q == DONE) begin
            wb_valid = 1'b1;
            wb_rd    = rd;
            unique case (kind)
                K_ALU, K_LUI: begin
                    wb_data = res_q;
                    wb_we   = (rd != '0);
                end
                K_SLT: begin
                    wb_data = {{(XLEN-1){1'b0}}, lt_s};
                    wb_we   = (rd != '0);
                end
                K_SLTU: begin
                    wb_data = {{(XLEN-1){1'b0}}, lt_u};
                    wb_we   = (rd != '0);
                end
                K_BR: br_taken = br_cond;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule
